// File: rtl/factor_row_fetch_responder.sv
// Factor-matrix row fetch responder: queues {row index per mode, compute id} requests,
// fetches one row per input mode over a shared read port and returns the tagged rows.
`timescale 1ns/1ps
module factor_row_fetch_responder #(
  parameter int TENSOR_DIMENSIONS      = 3,
  parameter int FACTOR_MATRIX_WIDTH    = 32,
  parameter int RANK_FACTOR_MATRIX     = 16,
  parameter int MODE_TENSOR_ADDR_WIDTH = 16,
  parameter int NUM_COMPUTE_UNITS      = 4,
  parameter int REQ_FIFO_DEPTH         = 4,
  parameter int MEM_ADDR_WIDTH         = 32,
  localparam int NM    = TENSOR_DIMENSIONS - 1,
  localparam int ROW_W = RANK_FACTOR_MATRIX * FACTOR_MATRIX_WIDTH,
  localparam int CID_W = $clog2(NUM_COMPUTE_UNITS) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NM-1:0]                        req_addr_en,
  input  logic [NM*MODE_TENSOR_ADDR_WIDTH-1:0] req_addr,
  input  logic [CID_W-1:0]                     req_compute_id,
  input  logic [NM*MEM_ADDR_WIDTH-1:0]         cfg_mode_base,
  output logic                                 mem_rd_req,
  output logic [MEM_ADDR_WIDTH-1:0]            mem_rd_addr,
  input  logic                                 mem_rd_gnt,
  input  logic                                 mem_rd_valid,
  input  logic [ROW_W-1:0]                     mem_rd_data,
  output logic [NM-1:0]                        rsp_factor_en,
  output logic [NM*ROW_W-1:0]                  rsp_factor_data,
  output logic [CID_W-1:0]                     rsp_compute_id,
  output logic                                 factor_data_ack,
  output logic                                 fifo_overflow,
  output logic                                 busy
);

  // state | meaning
  // IDLE  | waiting for a queued request; pops the FIFO head into the working register
  // ISSUE | read for mode m: request/address registered on the first cycle, held until granted
  // WAIT  | read outstanding; row captured into row[m] on mem_rd_valid
  // RESP  | all rows present; response outputs registered for the following cycle

  localparam int AW    = MODE_TENSOR_ADDR_WIDTH;
  localparam int MW    = MEM_ADDR_WIDTH;
  localparam int PTR_W = (REQ_FIFO_DEPTH > 1) ? $clog2(REQ_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = NM * AW + CID_W;
  localparam int M_W   = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [CID_W-1:0] NO_ID  = CID_W'(NUM_COMPUTE_UNITS);
  localparam logic [M_W-1:0]   LAST_M = M_W'(NM - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [ENT_W-1:0] fifo_mem [REQ_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             req_valid, fifo_full, fifo_empty, push, pop;

  logic [NM*AW-1:0]    work_addr;
  logic [CID_W-1:0]    work_id;
  logic [M_W-1:0]      m;
  logic [NM*ROW_W-1:0] rows;
  logic [MW-1:0]       issue_addr;

  assign req_valid  = (&req_addr_en) && (req_compute_id < NO_ID);
  assign fifo_full  = (count == CNT_W'(REQ_FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // full is judged on the registered count, so a same-cycle pop never frees a slot
  assign push       = req_valid && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign busy       = !fifo_empty || (state != IDLE);
  assign issue_addr = cfg_mode_base[m*MW +: MW] + MW'(work_addr[m*AW +: AW]);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_addr, req_compute_id};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      if (req_valid && fifo_full) fifo_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_nxt = ISSUE;
      ISSUE:   if (mem_rd_req && mem_rd_gnt) state_nxt = WAIT;
      WAIT:    if (mem_rd_valid) state_nxt = (m == LAST_M) ? RESP : ISSUE;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_addr       <= '0;
      work_id         <= NO_ID;
      m               <= '0;
      rows            <= '0;
      mem_rd_req      <= 1'b0;
      mem_rd_addr     <= '0;
      rsp_factor_en   <= '0;
      rsp_factor_data <= '0;
      rsp_compute_id  <= NO_ID;
      factor_data_ack <= 1'b0;
    end else begin
      if (pop) begin
        {work_addr, work_id} <= fifo_mem[rd_ptr];
        m                    <= '0;
      end
      // base is sampled once per read; address then holds through any grant stall
      if (state == ISSUE) begin
        if (!mem_rd_req) begin
          mem_rd_req  <= 1'b1;
          mem_rd_addr <= issue_addr;
        end else if (mem_rd_gnt) begin
          mem_rd_req  <= 1'b0;
        end
      end
      if ((state == WAIT) && mem_rd_valid) begin
        rows[m*ROW_W +: ROW_W] <= mem_rd_data;
        if (m != LAST_M) m <= m + M_W'(1);
      end
      rsp_factor_en   <= {NM{state == RESP}};
      factor_data_ack <= (state == RESP);
      rsp_compute_id  <= (state == RESP) ? work_id : NO_ID;
      if (state == RESP) rsp_factor_data <= rows;
    end
  end

endmodule

// File: tb/tb_factor_row_fetch_responder.sv
// Directed bench for factor_row_fetch_responder: latency-1 memory model with grant stalls
// and stray valids, hand-computed addresses, ids, latencies and row contents.
`timescale 1ns/1ps
module tb_factor_row_fetch_responder;

  localparam int NM    = 2;
  localparam int ROW_W = 512;
  localparam int CID_W = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NM-1:0]       req_addr_en;
  logic [NM*16-1:0]    req_addr;
  logic [CID_W-1:0]    req_compute_id;
  logic [NM*32-1:0]    cfg_mode_base;
  logic                mem_rd_req;
  logic [31:0]         mem_rd_addr;
  logic                mem_rd_gnt;
  logic                mem_rd_valid;
  logic [ROW_W-1:0]    mem_rd_data;
  logic [NM-1:0]       rsp_factor_en;
  logic [NM*ROW_W-1:0] rsp_factor_data;
  logic [CID_W-1:0]    rsp_compute_id;
  logic                factor_data_ack;
  logic                fifo_overflow;
  logic                busy;

  factor_row_fetch_responder dut (
    .clk(clk), .rst(rst),
    .req_addr_en(req_addr_en), .req_addr(req_addr), .req_compute_id(req_compute_id),
    .cfg_mode_base(cfg_mode_base),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .rsp_factor_en(rsp_factor_en), .rsp_factor_data(rsp_factor_data),
    .rsp_compute_id(rsp_compute_id), .factor_data_ack(factor_data_ack),
    .fifo_overflow(fifo_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          stall_req = 0;
  int          stray_req = 0;
  int          m_stall_seen = 0;
  int          m_stray_seen = 0;
  int          m_stall_cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] addr_q[$];

  function automatic logic [ROW_W-1:0] row_of(input logic [31:0] a);
    return {16{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // memory: grant when no stall pending, data one cycle after the grant edge
  initial begin
    mem_rd_gnt   = 1'b1;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      mem_rd_valid = 1'b0;
      if (pend) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = row_of(pend_addr);
        pend         = 1'b0;
      end else if (stray_req != m_stray_seen) begin
        m_stray_seen = stray_req;
        mem_rd_valid = 1'b1;
        mem_rd_data  = {16{32'hBADC_0FFE}};
      end
      if (stall_req != m_stall_seen) begin
        m_stall_seen = stall_req;
        m_stall_cnt  = 5;
      end
      mem_rd_gnt = (m_stall_cnt == 0);
      if (mem_rd_req && m_stall_cnt > 0) m_stall_cnt--;
      if (mem_rd_req && mem_rd_gnt) begin
        pend      = 1'b1;
        pend_addr = mem_rd_addr;
        addr_q.push_back(mem_rd_addr);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] en, input logic [31:0] addr, input logic [2:0] id);
    req_addr_en    = en;
    req_addr       = addr;
    req_compute_id = id;
    tick();
    req_addr_en    = 2'b00;
    req_compute_id = 3'd4;
  endtask

  task automatic wait_rsp(input int start, input int max, output int lat);
    lat = start;
    while (rsp_factor_en == 2'b00 && lat < max) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_rsp(input string tag, input logic [2:0] id, input logic [31:0] a0,
                           input logic [31:0] a1);
    chk({tag, "_en"}, rsp_factor_en, 2'b11);
    chk({tag, "_ack"}, factor_data_ack, 1'b1);
    chk({tag, "_id"}, rsp_compute_id, id);
    chk({tag, "_row0"}, rsp_factor_data[ROW_W-1:0], row_of(a0));
    chk({tag, "_row1"}, rsp_factor_data[2*ROW_W-1:ROW_W], row_of(a1));
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      tick();
      if (rsp_factor_en != 2'b00 || factor_data_ack) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, mem_rd_req, 1'b0);
    chk({tag, "_addr"}, mem_rd_addr, 32'h0);
    chk({tag, "_en"}, rsp_factor_en, 2'b00);
    chk({tag, "_row0"}, rsp_factor_data[ROW_W-1:0], '0);
    chk({tag, "_row1"}, rsp_factor_data[2*ROW_W-1:ROW_W], '0);
    chk({tag, "_id"}, rsp_compute_id, 3'd4);
    chk({tag, "_ack"}, factor_data_ack, 1'b0);
    chk({tag, "_ovf"}, fifo_overflow, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  logic [2:0] burst_id [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2};

  initial begin
    int lat;
    int base;
    req_addr_en    = 2'b00;
    req_addr       = '0;
    req_compute_id = 3'd4;
    cfg_mode_base  = {32'h0000_1000, 32'h0000_0000};

    repeat (3) tick();
    check_reset_outputs("rst_hold");
    rst = 1'b1;
    tick();

    // single request, immediate grant
    base = addr_q.size();
    drive_req(2'b11, {16'h0005, 16'h0002}, 3'd2);
    wait_rsp(0, 40, lat);
    chk("single_lat", lat, 8);
    check_rsp("single", 3'd2, 32'h2, 32'h1005);
    chk("single_nrd", addr_q.size() - base, 2);
    chk("single_rd0", addr_q[base], 32'h2);
    chk("single_rd1", addr_q[base+1], 32'h1005);
    tick();
    chk("single_en_drop", rsp_factor_en, 2'b00);
    chk("single_ack_drop", factor_data_ack, 1'b0);
    chk("single_id_idle", rsp_compute_id, 3'd4);
    chk("single_row_hold", rsp_factor_data[ROW_W-1:0], row_of(32'h2));
    chk("single_busy", busy, 1'b0);

    // five-cycle grant stall on the first read
    stall_req++;
    base = addr_q.size();
    drive_req(2'b11, {16'h0010, 16'h0003}, 3'd1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", mem_rd_req, 1'b1);
      chk("stall_addr", mem_rd_addr, 32'h3);
      tick();
    end
    wait_rsp(7, 60, lat);
    chk("stall_lat", lat, 13);
    check_rsp("stall", 3'd1, 32'h3, 32'h1010);
    chk("stall_rd0", addr_q[base], 32'h3);
    chk("stall_rd1", addr_q[base+1], 32'h1010);
    tick();

    // filtered requests and a stray valid in IDLE
    base = addr_q.size();
    drive_req(2'b11, {16'h0030, 16'h0031}, 3'd4);
    drive_req(2'b01, {16'h0032, 16'h0033}, 3'd1);
    stray_req++;
    expect_quiet("filt_rsp", 20);
    chk("filt_nrd", addr_q.size(), base);
    chk("filt_busy", busy, 1'b0);
    chk("filt_ovf", fifo_overflow, 1'b0);

    // burst of four, then a fifth (accepted) and sixth (dropped)
    for (int k = 0; k < 6; k++) begin
      req_addr_en    = 2'b11;
      req_addr       = {16'(16'h0100 + k), 16'(16'h0020 + k)};
      req_compute_id = burst_id[k];
      tick();
      if (k == 3 || k == 4) chk("burst_ovf_clear", fifo_overflow, 1'b0);
    end
    req_addr_en    = 2'b00;
    req_compute_id = 3'd4;
    chk("burst_ovf_set", fifo_overflow, 1'b1);
    for (int i = 0; i < 5; i++) begin
      wait_rsp(0, 40, lat);
      if (i > 0) chk("burst_spacing", lat, 7);
      check_rsp("burst", burst_id[i], 32'h20 + 32'(i), 32'h1100 + 32'(i));
      tick();
    end
    expect_quiet("burst_no_sixth", 30);
    chk("burst_ovf_sticky", fifo_overflow, 1'b1);
    chk("burst_busy", busy, 1'b0);

    // reset asserted while a read is outstanding
    drive_req(2'b11, {16'h0007, 16'h0004}, 3'd0);
    tick();
    tick();
    tick();
    chk("wait_busy", busy, 1'b1);
    chk("wait_addr", mem_rd_addr, 32'h4);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    tick();
    rst = 1'b1;
    stray_req++;
    expect_quiet("rst_no_rsp", 20);
    chk("rst_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
